// File: rtl/lane_reduce_acc_if.sv
// Beat input / packet result bus for lane_reduce_acc.
// master drives beats and out_ready; slave is the reducer side.
interface lane_reduce_acc_if #(
    parameter int NUM_LANES = 240,
    parameter int IN_WIDTH  = 17,
    parameter int ACC_WIDTH = 48
);
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_LANES*IN_WIDTH-1:0] in_data;
    logic                          in_last;
    logic                          out_valid;
    logic                          out_ready;
    logic [ACC_WIDTH-1:0]          out_sum;
    logic [15:0]                   out_beats;
    logic                          out_sat;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_beats, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_beats, out_sat
    );
endinterface

// File: rtl/lane_reduce_acc.sv
// Two-stage lane reducer: S1 sums all lanes of a beat, S2 accumulates beats
// of a packet with saturation and presents one held result per packet.
module lane_reduce_acc #(
    parameter int NUM_LANES = 240,
    parameter int IN_WIDTH  = 17,
    parameter int ACC_WIDTH = 48
) (
    input logic              clk,
    input logic              rst,
    lane_reduce_acc_if.slave bus
);
    localparam int SUM_W = IN_WIDTH + $clog2(NUM_LANES);
    localparam int EXT_W = ACC_WIDTH + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {ACC_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 freeze_s;
    logic                 transfer_s;
    logic [SUM_W-1:0]     lane_sum_s;
    logic [SUM_W-1:0]     s1_sum_r;
    logic                 s1_last_r;
    logic                 s1_valid_r;
    logic [ACC_WIDTH-1:0] acc_r;
    logic [15:0]          beats_r;
    logic                 sat_r;
    logic [ACC_WIDTH-1:0] base_acc_s;
    logic [15:0]          base_beats_s;
    logic                 base_sat_s;
    logic [EXT_W-1:0]     add_s;
    logic [ACC_WIDTH-1:0] new_acc_s;
    logic [15:0]          new_beats_s;
    logic                 new_sat_s;
    logic                 out_valid_r;
    logic [ACC_WIDTH-1:0] out_sum_r;
    logic [15:0]          out_beats_r;
    logic                 out_sat_r;

    // A pending result the consumer refuses stalls the whole pipeline.
    assign freeze_s      = out_valid_r & ~bus.out_ready;
    assign transfer_s    = bus.in_valid & ~freeze_s;
    assign bus.in_ready  = ~freeze_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = out_sum_r;
    assign bus.out_beats = out_beats_r;
    assign bus.out_sat   = out_sat_r;

    // Adder tree over all lanes of the incoming beat.
    always_comb begin
        lane_sum_s = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_sum_s = lane_sum_s + SUM_W'(bus.in_data[i*IN_WIDTH +: IN_WIDTH]);
        end
    end

    // S1 register: per-beat lane total.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_sum_r   <= '0;
        end else if (!freeze_s) begin
            s1_valid_r <= transfer_s;
            if (transfer_s) begin
                s1_sum_r  <= lane_sum_s;
                s1_last_r <= bus.in_last;
            end
        end
    end

    // S2 next state: IDLE starts a fresh packet, ACCUM extends the open one.
    always_comb begin
        base_acc_s   = '0;
        base_beats_s = 16'd0;
        base_sat_s   = 1'b0;
        case (state_r)
            IDLE: begin
                base_acc_s   = '0;
                base_beats_s = 16'd0;
                base_sat_s   = 1'b0;
            end
            ACCUM: begin
                base_acc_s   = acc_r;
                base_beats_s = beats_r;
                base_sat_s   = sat_r;
            end
            default: begin
                base_acc_s   = '0;
                base_beats_s = 16'd0;
                base_sat_s   = 1'b0;
            end
        endcase

        add_s = {1'b0, base_acc_s} + EXT_W'(s1_sum_r);
        if (add_s[ACC_WIDTH]) begin
            new_acc_s = ACC_MAX;
            new_sat_s = 1'b1;
        end else begin
            new_acc_s = add_s[ACC_WIDTH-1:0];
            new_sat_s = base_sat_s;
        end

        if (base_beats_s == 16'hFFFF) begin
            new_beats_s = base_beats_s;
        end else begin
            new_beats_s = base_beats_s + 16'd1;
        end

        state_nxt_s = state_r;
        if (s1_valid_r) begin
            if (s1_last_r) begin
                state_nxt_s = IDLE;
            end else begin
                state_nxt_s = ACCUM;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // S2 state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else if (!freeze_s) begin
            state_r <= state_nxt_s;
        end
    end

    // Running packet accumulator, emptied when a packet closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r   <= '0;
            beats_r <= 16'd0;
            sat_r   <= 1'b0;
        end else if (!freeze_s && s1_valid_r) begin
            if (s1_last_r) begin
                acc_r   <= '0;
                beats_r <= 16'd0;
                sat_r   <= 1'b0;
            end else begin
                acc_r   <= new_acc_s;
                beats_r <= new_beats_s;
                sat_r   <= new_sat_s;
            end
        end
    end

    // Result holding register; a new result may replace one consumed this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_sum_r   <= '0;
            out_beats_r <= 16'd0;
            out_sat_r   <= 1'b0;
        end else if (!freeze_s) begin
            if (s1_valid_r && s1_last_r) begin
                out_valid_r <= 1'b1;
                out_sum_r   <= new_acc_s;
                out_beats_r <= new_beats_s;
                out_sat_r   <= new_sat_s;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lane_reduce_acc.sv
// Directed bench for lane_reduce_acc with a packet-level reference model
// checked every cycle plus literal checkpoints at fixed cycles.
module tb_lane_reduce_acc;
    localparam int NL = 4;
    localparam int IW = 17;
    localparam int AW = 20;
    localparam longint ACC_MAX = (longint'(1) << AW) - longint'(1);

    typedef struct {
        longint sum;
        int     beats;
        bit     sat;
    } res_t;

    typedef struct {
        int     at;
        bit     v;
        bit     rdy;
        bit     chk;
        longint sum;
        int     beats;
        bit     sat;
    } pin_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lane_reduce_acc_if #(.NUM_LANES(NL), .IN_WIDTH(IW), .ACC_WIDTH(AW)) bus ();

    lane_reduce_acc #(.NUM_LANES(NL), .IN_WIDTH(IW), .ACC_WIDTH(AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    res_t   expq[$];
    pin_t   pins[$];
    int     pin_rd = 0;
    int     cyc    = 0;
    int     total  = 0;
    int     bad    = 0;
    bit     done   = 1'b0;
    longint m_acc  = 0;
    int     m_beats = 0;
    bit     m_sat  = 1'b0;

    function automatic logic [NL*IW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [NL*IW-1:0] v;
        v = '0;
        v[0*IW +: IW] = IW'(a);
        v[1*IW +: IW] = IW'(b);
        v[2*IW +: IW] = IW'(c);
        v[3*IW +: IW] = IW'(d);
        return v;
    endfunction

    // Outputs are checked at the falling edge; the model then advances
    // by what the next rising edge will do with the inputs now present.
    always @(negedge clk) begin : cmp
        pin_t   p;
        res_t   r;
        longint s;
        cyc = cyc + 1;

        while (pin_rd < pins.size() && pins[pin_rd].at <= cyc) begin
            p = pins[pin_rd];
            if (p.at == cyc) begin
                total++;
                if (bus.out_valid !== p.v) begin
                    bad++;
                    $display("FAIL pin_out_valid cyc=%0d got=%b want=%b", cyc, bus.out_valid, p.v);
                end
                total++;
                if (bus.in_ready !== p.rdy) begin
                    bad++;
                    $display("FAIL pin_in_ready cyc=%0d got=%b want=%b", cyc, bus.in_ready, p.rdy);
                end
                if (p.chk) begin
                    total++;
                    if (bus.out_sum !== AW'(p.sum) || bus.out_beats !== 16'(p.beats) || bus.out_sat !== p.sat) begin
                        bad++;
                        $display("FAIL pin_result cyc=%0d got sum=%0d beats=%0d sat=%b want sum=%0d beats=%0d sat=%b",
                                 cyc, bus.out_sum, bus.out_beats, bus.out_sat, p.sum, p.beats, p.sat);
                    end
                end
            end else begin
                total++;
                bad++;
                $display("FAIL pin_missed at=%0d now=%0d", p.at, cyc);
            end
            pin_rd++;
        end

        total++;
        if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
            bad++;
            $display("FAIL in_ready_rule cyc=%0d got=%b ov=%b ordy=%b", cyc, bus.in_ready, bus.out_valid, bus.out_ready);
        end

        if (bus.out_valid === 1'b1) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result cyc=%0d got sum=%0d want none", cyc, bus.out_sum);
            end else begin
                r = expq[0];
                if (bus.out_sum !== AW'(r.sum) || bus.out_beats !== 16'(r.beats) || bus.out_sat !== r.sat) begin
                    bad++;
                    $display("FAIL model_result cyc=%0d got sum=%0d beats=%0d sat=%b want sum=%0d beats=%0d sat=%b",
                             cyc, bus.out_sum, bus.out_beats, bus.out_sat, r.sum, r.beats, r.sat);
                end
            end
        end

        if (rst) begin
            expq.delete();
            m_beats = 0;
            m_acc   = 0;
            m_sat   = 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready && expq.size() > 0) begin
                void'(expq.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                s = 0;
                for (int i = 0; i < NL; i++) begin
                    s = s + longint'(bus.in_data[i*IW +: IW]);
                end
                m_acc = m_acc + s;
                if (m_acc > ACC_MAX) begin
                    m_acc = ACC_MAX;
                    m_sat = 1'b1;
                end
                m_beats = (m_beats >= 65535) ? 65535 : m_beats + 1;
                if (bus.in_last) begin
                    r.sum   = m_acc;
                    r.beats = m_beats;
                    r.sat   = m_sat;
                    expq.push_back(r);
                    m_acc   = 0;
                    m_beats = 0;
                    m_sat   = 1'b0;
                end
            end
        end

        if (done) begin
            total++;
            if (expq.size() != 0) begin
                bad++;
                $display("FAIL results_pending got=%0d want=0", expq.size());
            end
            total++;
            if (pin_rd != pins.size()) begin
                bad++;
                $display("FAIL pins_unchecked got=%0d want=%0d", pin_rd, pins.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input int at, input bit v, input bit rdy, input bit chk,
                       input longint s, input int b, input bit st);
        pin_t p;
        p.at = at; p.v = v; p.rdy = rdy; p.chk = chk;
        p.sum = s; p.beats = b; p.sat = st;
        pins.push_back(p);
    endtask

    task automatic send(input logic [NL*IW-1:0] d, input bit last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin : stim
        int n;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        pin(cyc + 1, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        tick();

        // single beat: result exactly two cycles after the transfer
        n = cyc + 1;
        send(pack4(1, 2, 3, 4), 1'b1);
        pin(n + 1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        pin(n + 2, 1'b1, 1'b1, 1'b1, 10, 1, 1'b0);
        pin(n + 3, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        repeat (3) tick();

        // multi-beat
        n = cyc + 1;
        send(pack4(100, 100, 100, 100), 1'b0);
        send(pack4(100, 100, 100, 100), 1'b0);
        send(pack4(100, 100, 100, 100), 1'b1);
        pin(n + 4, 1'b1, 1'b1, 1'b1, 1200, 3, 1'b0);
        repeat (3) tick();

        // saturation on the third beat
        n = cyc + 1;
        send(pack4(131071, 131071, 131071, 131071), 1'b0);
        send(pack4(131071, 131071, 131071, 131071), 1'b0);
        send(pack4(131071, 131071, 131071, 131071), 1'b1);
        pin(n + 4, 1'b1, 1'b1, 1'b1, 1048575, 3, 1'b1);
        repeat (3) tick();

        // backpressure: held result, stalled input, then release
        bus.out_ready = 1'b0;
        n = cyc + 1;
        send(pack4(10, 20, 30, 40), 1'b1);
        tick();
        for (int k = 0; k < 5; k++) begin
            pin(n + 2 + k, 1'b1, 1'b0, 1'b1, 100, 1, 1'b0);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = pack4(1, 1, 1, 1);
        bus.in_last  = 1'b1;
        repeat (5) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        pin(n + 8, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        pin(n + 9, 1'b1, 1'b1, 1'b1, 4, 1, 1'b0);
        repeat (3) tick();

        // reset mid-packet leaves no residue
        send(pack4(7, 7, 7, 7), 1'b0);
        send(pack4(7, 7, 7, 7), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pin(cyc + 1, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        n = cyc + 1;
        send(pack4(5, 5, 5, 5), 1'b1);
        pin(n + 2, 1'b1, 1'b1, 1'b1, 20, 1, 1'b0);
        repeat (3) tick();

        // back-to-back single-beat packets
        n = cyc + 1;
        for (int k = 1; k <= 4; k++) begin
            pin(n + 1 + k, 1'b1, 1'b1, 1'b1, 10 * k, 1, 1'b0);
        end
        pin(n + 6, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            send(pack4(k, 2 * k, 3 * k, 4 * k), 1'b1);
        end
        repeat (4) tick();

        done = 1'b1;
        repeat (10) tick();
        $display("FAIL summary_not_reached");
        $fatal(1);
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end
endmodule
